// File: rtl/bus_pkg.sv
// Shared types and constants for the serial bus scheduler: FSM states,
// default field widths, frame length and the on-wire frame layout.
package bus_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } state_t;

   // Default geometry of the node bus
   localparam int DEF_N_NODES = 16;
   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_DATA_W  = 64;
   localparam int DEF_CRC_W   = 4;

   // Total bits on the wire per frame, start bit included
   localparam int FRAME_LEN = 1 + 2 * DEF_ADDR_W + DEF_DATA_W + DEF_CRC_W;

   // Frame layout, first field is transmitted first (MSB first)
   typedef struct packed {
      logic                  start;
      logic [DEF_ADDR_W-1:0] src;
      logic [DEF_ADDR_W-1:0] dst;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_CRC_W-1:0]  crc;
   } frame_t;

endpackage

// File: rtl/serial_bus_scheduler_rr_arbiter.sv
// Combinational round-robin picker: scans from the node after the last
// winner, wrapping around, and returns the first requester found.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int N_NODES = DEF_N_NODES,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic [N_NODES-1:0] req,
   input  logic [ADDR_W-1:0]  last,
   output logic [N_NODES-1:0] win,
   output logic [ADDR_W-1:0]  win_idx
);

   logic              found;
   logic [ADDR_W-1:0] cand;

   // Priority search starting one past the previous winner
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N_NODES; i++) begin
         cand = ADDR_W'((int'(last) + i) % N_NODES);
         if (!found && req[cand]) begin
            found     = 1'b1;
            win[cand] = 1'b1;
            win_idx   = cand;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/serial_bus_scheduler.sv
// Round-robin bus arbiter and frame serializer. Grants one node at a time,
// latches that node's fields through the external grant-indexed mux and
// shifts a fixed-format frame onto the 1-bit bus, followed by idle gap cycles.
module serial_bus_scheduler
   import bus_pkg::*;
#(
   parameter int N_NODES    = DEF_N_NODES,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CRC_W      = DEF_CRC_W,
   parameter int GAP_CYCLES = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_NODES-1:0] req,
   input  logic [ADDR_W-1:0]  dst_addr,
   input  logic [DATA_W-1:0]  data,
   input  logic [CRC_W-1:0]   crc,
   output logic [N_NODES-1:0] grant,
   output logic [ADDR_W-1:0]  grant_idx,
   output logic               busy,
   output logic               bus_show,
   output logic               frame_done
);

   localparam int FLEN  = 1 + 2 * ADDR_W + DATA_W + CRC_W;
   localparam int CNT_W = $clog2(FLEN);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t              state;
   logic [ADDR_W-1:0]   last;
   // The frame MSB goes straight to bus_show on load, so only the rest is kept
   logic [FLEN-2:0]     shreg;
   logic [CNT_W-1:0]    bit_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic [N_NODES-1:0]  win;
   logic [ADDR_W-1:0]   win_idx;
   logic                req_any;
   logic [FLEN-1:0]     frame_word;

   rr_arbiter #(
      .N_NODES (N_NODES),
      .ADDR_W  (ADDR_W)
   ) u_arb (
      .req     (req),
      .last    (last),
      .win     (win),
      .win_idx (win_idx)
   );

   assign req_any    = |req;
   // Source field comes from our own registered grant; the rest from the mux
   assign frame_word = {1'b1, grant_idx, dst_addr, data, crc};

   // Scheduler FSM: arbitration, frame load, serialization and gap timing
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         grant_idx  <= '0;
         busy       <= 1'b0;
         bus_show   <= 1'b0;
         frame_done <= 1'b0;
         last       <= ADDR_W'(N_NODES - 1);
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus_show   <= 1'b0;
               frame_done <= 1'b0;
               if (req_any) begin
                  grant     <= win;
                  grant_idx <= win_idx;
                  last      <= win_idx;
                  busy      <= 1'b1;
                  state     <= LOAD;
               end else begin
                  grant <= '0;
                  busy  <= 1'b0;
               end
            end

            LOAD: begin
               // Mux outputs are valid now because they follow grant_idx
               bus_show   <= frame_word[FLEN-1];
               shreg      <= frame_word[FLEN-2:0];
               bit_cnt    <= CNT_W'(FLEN - 1);
               frame_done <= 1'b0;
               state      <= SEND;
            end

            SEND: begin
               if (bit_cnt == '0) begin
                  bus_show   <= 1'b0;
                  frame_done <= 1'b1;
                  gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                  state      <= GAP;
               end else begin
                  bus_show <= shreg[FLEN-2];
                  shreg    <= {shreg[FLEN-3:0], 1'b0};
                  bit_cnt  <= bit_cnt - CNT_W'(1);
               end
            end

            GAP: begin
               bus_show   <= 1'b0;
               frame_done <= 1'b0;
               if (gap_cnt == '0) begin
                  if (req_any) begin
                     // Back-to-back frame: new owner chosen on the gap's last edge
                     grant     <= win;
                     grant_idx <= win_idx;
                     last      <= win_idx;
                     state     <= LOAD;
                  end else begin
                     grant <= '0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end

            default: begin
               state      <= IDLE;
               grant      <= '0;
               busy       <= 1'b0;
               bus_show   <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bus_scheduler.sv
// Self-checking bench for serial_bus_scheduler: a queue-based reference
// model predicts every output cycle, plus table-driven arbitration-order
// vectors and hand-written latency, drop, reset and sequence scenarios.
module tb_serial_bus_scheduler;
   import bus_pkg::*;

   localparam int NN = 16;
   localparam int FL = FRAME_LEN;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] req   = 16'h0;
   logic [3:0]  dst_addr;
   logic [63:0] data;
   logic [3:0]  crc;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   logic        busy, bus_show, frame_done;

   // Per-node register banks, read through the grant-indexed mux
   logic [3:0]  node_dst  [NN];
   logic [63:0] node_data [NN];
   logic [3:0]  node_crc  [NN];

   assign dst_addr = node_dst[grant_idx];
   assign data     = node_data[grant_idx];
   assign crc      = node_crc[grant_idx];

   serial_bus_scheduler dut (
      .clock(clock), .reset(reset), .req(req), .dst_addr(dst_addr),
      .data(data), .crc(crc), .grant(grant), .grant_idx(grant_idx),
      .busy(busy), .bus_show(bus_show), .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, expv);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [15:0] grant;
      logic [3:0]  idx;
      logic        busy;
      logic        bus;
      logic        fd;
   } obs_t;

   obs_t exp_q[$];
   obs_t exp_now = '0;
   obs_t obs_now;
   int   m_last  = NN - 1;
   int   m_idx   = 0;

   function automatic int rr_pick(input logic [15:0] r, input int lst);
      for (int k = 1; k <= NN; k++) begin
         int c = (lst + k) % NN;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   function automatic logic [FL-1:0] frame_of(input int node);
      frame_t f;
      f.start = 1'b1;
      f.src   = 4'(node);
      f.dst   = node_dst[node];
      f.data  = node_data[node];
      f.crc   = node_crc[node];
      return f;
   endfunction

   // Plan a whole frame: one load cycle, FL bits, one gap cycle
   task automatic plan_frame(input int w);
      logic [FL-1:0] fr;
      logic [15:0]   oh;
      fr     = frame_of(w);
      oh     = 16'h1 << w;
      m_last = w;
      m_idx  = w;
      exp_q.push_back({oh, 4'(w), 1'b1, 1'b0, 1'b0});
      for (int b = FL - 1; b >= 0; b--) exp_q.push_back({oh, 4'(w), 1'b1, fr[b], 1'b0});
      exp_q.push_back({oh, 4'(w), 1'b1, 1'b0, 1'b1});
   endtask

   // Model step: bus is free whenever nothing is planned
   always @(posedge clock) begin
      cyc = cyc + 1;
      if (reset) begin
         exp_q.delete();
         m_last  = NN - 1;
         m_idx   = 0;
         exp_now = '0;
      end else begin
         if (exp_q.size() == 0 && req != 16'h0) plan_frame(rr_pick(req, m_last));
         if (exp_q.size() != 0) exp_now = exp_q.pop_front();
         else exp_now = {16'h0, 4'(m_idx), 1'b0, 1'b0, 1'b0};
      end
   end

   logic [3:0] fd_idx_q[$];
   int         fd_cyc_q[$];

   // Per-cycle comparison against the model and frame_done logging
   always @(negedge clock) begin
      obs_now = {grant, grant_idx, busy, bus_show, frame_done};
      check("cycle_model", obs_now, exp_now);
      if (frame_done) begin
         fd_idx_q.push_back(grant_idx);
         fd_cyc_q.push_back(cyc);
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(negedge clock); #1;
      reset = 1'b1;
      req   = 16'h0;
      repeat (2) @(negedge clock);
      #1;
      fd_idx_q.delete();
      fd_cyc_q.delete();
      reset = 1'b0;
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return grant != 16'h0;
         1:       return bus_show;
         default: return frame_done;
      endcase
   endfunction

   task automatic wait_for(input int which, input int budget, output int n);
      bit hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clock);
         n++;
         hit = cond(which);
      end
      check("wait_done", hit, 1);
   endtask

   // Called at the negedge showing the start bit; leaves us at the last bit
   task automatic capture(input int drop_at, output logic [FL-1:0] f);
      f[FL-1] = bus_show;
      for (int k = FL - 2; k >= 0; k--) begin
         @(negedge clock);
         f[k] = bus_show;
         if ((FL - 1 - k) == drop_at) begin
            #1 req = 16'h0;
         end
      end
   endtask

   typedef struct {
      logic [15:0]     req;
      logic [3:0][3:0] order;
   } vec_t;
   vec_t vecs [4];

   initial begin
      int            n1, n2, n3;
      logic [FL-1:0] f;
      bit            quiet;

      for (int i = 0; i < NN; i++) begin
         node_dst[i]  = 4'(i ^ 5);
         node_data[i] = {32'(i) * 32'h01010101, 32'hC0DE0000 | 32'(i)};
         node_crc[i]  = 4'(15 - i);
      end
      node_dst[0] = 4'h1; node_data[0] = 64'h1; node_crc[0] = 4'h1;
      node_dst[1] = 4'hA; node_data[1] = 64'hFFFF_FFFF_FFFF_FFFF; node_crc[1] = 4'h5;
      node_dst[2] = 4'h3; node_data[2] = 64'h0123_4567_89AB_CDEF; node_crc[2] = 4'hC;

      // Arbitration order vectors: req held from reset, first four grants
      vecs[0].req = 16'h0001; vecs[0].order = {4'd0, 4'd0, 4'd0, 4'd0};
      vecs[1].req = 16'h0007; vecs[1].order = {4'd0, 4'd2, 4'd1, 4'd0};
      vecs[2].req = 16'h8001; vecs[2].order = {4'd15, 4'd0, 4'd15, 4'd0};
      vecs[3].req = 16'h0A50; vecs[3].order = {4'd11, 4'd9, 4'd6, 4'd4};

      repeat (2) @(negedge clock);
      #1 reset = 1'b0;
      check("reset_state", {grant, grant_idx, busy, bus_show, frame_done}, 23'h0);

      for (int v = 0; v < 4; v++) begin
         int b;
         do_reset();
         req = vecs[v].req;
         b = 0;
         while (fd_idx_q.size() < 4 && b < 400) begin
            @(negedge clock);
            b++;
         end
         check("order_frames", fd_idx_q.size() >= 4, 1);
         if (fd_idx_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
               check("order_idx", fd_idx_q[k], vecs[v].order[k]);
               if (k > 0) check("order_spacing", fd_cyc_q[k] - fd_cyc_q[k-1], 1 + FL + 1);
            end
         end
         req = 16'h0;
         repeat (100) @(negedge clock);
      end

      // Single frame from node 0: latency and exact bit stream
      do_reset();
      req = 16'h0001;
      wait_for(0, 10, n1);
      check("t1_grant_latency", n1, 1);
      check("t1_grant", grant, 16'h0001);
      #1 req = 16'h0;
      wait_for(1, 10, n2);
      check("t1_start_latency", n1 + n2, 2);
      capture(-1, f);
      check("t1_frame_bits", f, {1'b1, 4'h0, 4'h1, 64'h1, 4'h1});
      wait_for(2, 10, n3);
      check("t1_done_offset", (FL - 1) + n3, 77);
      repeat (5) @(negedge clock);
      check("t1_idle", {grant, busy, bus_show}, 18'h0);

      // Request dropped 10 bits into the frame: frame still completes
      do_reset();
      req = 16'h0002;
      wait_for(0, 10, n1);
      check("drop_grant", grant, 16'h0002);
      wait_for(1, 10, n2);
      capture(10, f);
      check("drop_frame_bits", f, frame_of(1));
      wait_for(2, 10, n3);
      repeat (3) @(negedge clock);
      check("drop_idle", {grant, busy, bus_show}, 18'h0);

      // Asynchronous reset in the middle of the data field
      do_reset();
      req = 16'h0002;
      wait_for(0, 10, n1);
      wait_for(1, 10, n2);
      repeat (30) @(negedge clock);
      check("rst_pre_bus", bus_show, 1);
      #1 reset = 1'b1;
      #1 check("rst_async", {grant, grant_idx, busy, bus_show, frame_done}, 23'h0);
      @(negedge clock);
      #1;
      reset = 1'b0;
      req   = 16'h0004;
      wait_for(0, 10, n1);
      check("rst_regrant", grant, 16'h0004);
      #1 req = 16'h0;
      wait_for(1, 10, n2);
      capture(-1, f);
      check("rst_frame_bits", f, frame_of(2));

      // Request walk 1 -> 2 -> 4 -> 0, changing every 84 cycles mid-cycle.
      // Node 0 still requests at the end of its first frame, so it is granted twice.
      do_reset();
      req = 16'h0001;
      repeat (84) @(negedge clock);
      #1 req = 16'h0002;
      repeat (84) @(negedge clock);
      #1 req = 16'h0004;
      repeat (84) @(negedge clock);
      #1 req = 16'h0000;
      repeat (160) @(negedge clock);
      check("seq_frames", fd_idx_q.size(), 4);
      if (fd_idx_q.size() == 4) begin
         check("seq_order", {fd_idx_q[0], fd_idx_q[1], fd_idx_q[2], fd_idx_q[3]}, 16'h0012);
      end
      quiet = 1'b1;
      repeat (40) begin
         @(negedge clock);
         if (busy || bus_show) quiet = 1'b0;
      end
      check("seq_quiet", quiet, 1);

      // Randomized traffic with fresh node contents, checked by the model
      do_reset();
      for (int i = 0; i < NN; i++) begin
         node_dst[i]  = 4'($urandom);
         node_data[i] = {$urandom, $urandom};
         node_crc[i]  = 4'($urandom);
      end
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         #1;
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       req = 16'h0;
               1:       req = 16'h1 << $urandom_range(0, 15);
               default: req = 16'($urandom) & 16'($urandom);
            endcase
         end
         if (c == 2000) reset = 1'b1;
         if (c == 2003) reset = 1'b0;
      end
      req = 16'h0;
      repeat (100) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
